demux_1x8_32bit_buf: RTL and testbench
======================================

// Module: demux_1x8_32bit_buf
// PURPOSE
//  Inverse of the 8:1 datapath select: routes one 32-bit word to one of 8 destination
//  channels, or to all 8 in broadcast mode, chosen by sel_2/sel_1/sel_0.
//  Each channel holds its word in a 1-deep output register until that consumer accepts it.
//  Transfers on both sides use valid/ready handshakes.
//  Sits between the ALU/result stage and the 8 per-destination consumers.
// PARAMETERS
//  WIDTH   32   data word width per channel
//  CNT_W   16   width of accepted-transfer counter
// PORTS
//  clk        in   1          rising-edge clock, the block's only clock
//  reset      in   1          asynchronous, active-high reset
//  in_valid   in   1          producer has a word on in_data
//  in_ready   out  1          block accepts in_data this cycle
//  in_data    in   WIDTH      word to route
//  bcast      in   1          1 = write all 8 channels, 0 = write only the selected channel
//  sel_2      in   1          channel select MSB
//  sel_1      in   1          channel select
//  sel_0      in   1          channel select LSB
//  out_bus    out  8*WIDTH    channel k data = out_bus[k*WIDTH +: WIDTH]
//  out_valid  out  8          channel k holds an unconsumed word
//  out_ready  in   8          consumer k takes its word this cycle
//  xfer_count out  CNT_W      number of accepted input transfers
// BEHAVIOUR
//  - reset (async assert, any time): out_valid=0, out_bus=0, xfer_count=0.
//    Any pending words are discarded. After reset, in_ready=1 (all channels free).
//  - free[k] = !out_valid[k] | out_ready[k].
//  - in_ready = bcast ? &free : free[{sel_2,sel_1,sel_0}]. This is a combinational
//    path from out_ready/sel/bcast; there is no path from in_valid to in_ready.
//  - accept = in_valid & in_ready.
//  - On accept, at the next edge the target channel(s) load in_data and set out_valid.
//    Latency: word is visible on out_bus with out_valid=1 one cycle after accept.
//  - Non-target channel with out_valid & out_ready: clears out_valid. out_bus data is
//    held, not zeroed.
//  - Same channel popped and loaded in one cycle: load wins; out_valid stays 1 with
//    the new data. Back-to-back throughput of 1 word/cycle per channel.
//  - While out_valid[k] & !out_ready[k], channel k data and valid are held stable.
//  - Broadcast accept loads all 8 channels simultaneously and requires all 8 free.
//    A partial broadcast never occurs.
//  - xfer_count += 1 per accept; a broadcast counts as 1. Wraps from 2^CNT_W-1 to 0.
//  - sel/bcast may change while in_valid=1 and not yet accepted. The block only uses
//    their values in the accept cycle.
//  - in_valid=0: no channel is loaded and xfer_count holds, regardless of sel/bcast.
// TESTING
//  1. Reset mid-traffic (ch3 valid, stalled) -> out_valid=8'h00, out_bus=0,
//     xfer_count=0, in_ready=1.
//  2. Single route: sel=3'b101, in_data=32'hDEADBEEF, 1-cycle valid -> next cycle
//     out_valid=8'h20, out_bus[191:160]=32'hDEADBEEF, xfer_count=1.
//  3. Backpressure: ch2 full and out_ready[2]=0, sel=2 with in_valid=1 -> in_ready=0;
//     ch2 data unchanged. Raise out_ready[2] -> same cycle in_ready=1; next cycle
//     ch2 = new word, out_valid[2]=1.
//  4. Broadcast: bcast=1, in_data=32'h0000_00A5, ch6 full and stalled -> in_ready=0,
//     no channel written. Release ch6 -> all 8 channels = 32'hA5, out_valid=8'hFF,
//     xfer_count +1.
//  5. Streaming: sel=0, in_valid=1 and out_ready[0]=1 for 10 cycles, incrementing
//     data 1..10 -> ch0 shows 1..10 on consecutive cycles, out_valid[0] stays 1,
//     xfer_count=10.
//  6. Wrap: CNT_W=4, 17 accepts -> xfer_count sequence reaches 15, then 0, then ends
//     at 1.

Source files
------------

// File: rtl/demux_1x8_32bit_buf_if.sv
// Handshake and data bundle for the 1:8 buffered demultiplexer.
// The master side is the producer plus the 8 consumers. The slave side is the demux itself.
interface demux_1x8_32bit_buf_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_data;
    logic                 bcast;
    logic                 sel_2;
    logic                 sel_1;
    logic                 sel_0;
    logic [8*WIDTH-1:0]   out_bus;
    logic [7:0]           out_valid;
    logic [7:0]           out_ready;
    logic [CNT_W-1:0]     xfer_count;

    modport master (
        output in_valid, in_data, bcast, sel_2, sel_1, sel_0, out_ready,
        input  in_ready, out_bus, out_valid, xfer_count
    );

    modport slave (
        input  in_valid, in_data, bcast, sel_2, sel_1, sel_0, out_ready,
        output in_ready, out_bus, out_valid, xfer_count
    );
endinterface

// File: rtl/demux_1x8_32bit_buf.sv
// 1:8 demultiplexer with a 1-deep output register per channel.
// It routes one word to the selected channel, or to all 8 channels in broadcast mode.
// It counts accepted input transfers in a counter that wraps.
module demux_1x8_32bit_buf #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    demux_1x8_32bit_buf_if.slave  bus
);
    logic [WIDTH-1:0]   data_q  [8];
    logic [WIDTH-1:0]   data_d  [8];
    logic [7:0]         valid_q;
    logic [7:0]         valid_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;

    logic [2:0]         sel_idx;
    logic [7:0]         free;
    logic [7:0]         load;
    logic               ready;
    logic               accept;
    logic [8*WIDTH-1:0] out_bus_c;

    // Compute the handshake and the next state of each channel.
    // When a channel is popped and loaded in the same cycle, the load wins.
    always_comb begin
        sel_idx = {bus.sel_2, bus.sel_1, bus.sel_0};
        free    = ~valid_q | bus.out_ready;
        ready   = bus.bcast ? (&free) : free[sel_idx];
        accept  = bus.in_valid & ready;
        load    = '0;
        valid_d = valid_q;
        for (int unsigned k = 0; k < 8; k++) begin
            data_d[k] = data_q[k];
            load[k]   = accept & (bus.bcast | (sel_idx == 3'(k)));
            if (load[k]) begin
                data_d[k]  = bus.in_data;
                valid_d[k] = 1'b1;
            end else if (bus.out_ready[k]) begin
                valid_d[k] = 1'b0;
            end
        end
        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, accept};
    end

    // Channel registers and the transfer counter. Reset is asynchronous.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            cnt_q   <= '0;
            for (int unsigned k = 0; k < 8; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
            for (int unsigned k = 0; k < 8; k++) begin
                data_q[k] <= data_d[k];
            end
        end
    end

    // Pack the channel registers onto the flat output bus.
    always_comb begin
        out_bus_c = '0;
        for (int unsigned k = 0; k < 8; k++) begin
            out_bus_c[k*WIDTH +: WIDTH] = data_q[k];
        end
    end

    assign bus.in_ready   = ready;
    assign bus.out_valid  = valid_q;
    assign bus.out_bus    = out_bus_c;
    assign bus.xfer_count = cnt_q;
endmodule

// File: tb/tb_demux_1x8_32bit_buf.sv
// Self-checking bench for demux_1x8_32bit_buf.
// A directed vector table, hand-written corner sequences and random traffic are each
// checked against an array-based reference model.
module tb_demux_1x8_32bit_buf;
    logic clk;
    logic reset;

    demux_1x8_32bit_buf_if #(.WIDTH(32), .CNT_W(16)) bus ();
    demux_1x8_32bit_buf_if #(.WIDTH(32), .CNT_W(4))  bw  ();

    demux_1x8_32bit_buf #(.WIDTH(32), .CNT_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    demux_1x8_32bit_buf #(.WIDTH(32), .CNT_W(4)) dut_wrap (
        .clk   (clk),
        .reset (reset),
        .bus   (bw)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: stored word per channel, valid flags and transfer count.
    logic [31:0] m_data [8];
    logic [7:0]  m_valid;
    logic [15:0] m_cnt;

    typedef struct {
        logic        v;
        logic        b;
        logic [2:0]  sel;
        logic [31:0] data;
        logic [7:0]  ordy;
        logic        exp_rdy;
        logic [7:0]  exp_valid;
        logic [15:0] exp_cnt;
        int          exp_ch;
        logic [31:0] exp_word;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 8; k++) m_data[k] = '0;
        m_valid = '0;
        m_cnt   = '0;
    endtask

    function automatic logic [255:0] model_bus();
        logic [255:0] r;
        for (int k = 0; k < 8; k++) r[k*32 +: 32] = m_data[k];
        return r;
    endfunction

    function automatic logic [31:0] ch_word(input int k);
        logic [255:0] b;
        b = bus.out_bus;
        return b[k*32 +: 32];
    endfunction

    task automatic drive(input logic v, input logic b, input logic [2:0] sel,
                         input logic [31:0] data, input logic [7:0] ordy);
        bus.in_valid  = v;
        bus.bcast     = b;
        {bus.sel_2, bus.sel_1, bus.sel_0} = sel;
        bus.in_data   = data;
        bus.out_ready = ordy;
    endtask

    // Runs one clock cycle with the inputs that are currently driven.
    // It checks in_ready before the edge and checks all outputs after the edge.
    task automatic cycle(output logic rdy_seen);
        logic [7:0]  free;
        logic        rdy;
        logic        acc;
        logic [2:0]  sel;
        logic [31:0] nd [8];
        logic [7:0]  nv;
        #1;
        sel  = {bus.sel_2, bus.sel_1, bus.sel_0};
        free = ~m_valid | bus.out_ready;
        rdy  = bus.bcast ? (free == 8'hFF) : free[sel];
        acc  = bus.in_valid && rdy;
        rdy_seen = bus.in_ready;
        chk("in_ready", {255'd0, bus.in_ready}, {255'd0, rdy});
        nv = m_valid;
        for (int k = 0; k < 8; k++) begin
            nd[k] = m_data[k];
            if (acc && (bus.bcast || sel == k)) begin
                nd[k] = bus.in_data;
                nv[k] = 1'b1;
            end else if (bus.out_ready[k]) begin
                nv[k] = 1'b0;
            end
        end
        @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 8; k++) m_data[k] = nd[k];
        m_valid = nv;
        if (acc) m_cnt = m_cnt + 16'd1;
        chk("out_valid", {248'd0, bus.out_valid}, {248'd0, m_valid});
        chk("out_bus", bus.out_bus, model_bus());
        chk("xfer_count", {240'd0, bus.xfer_count}, {240'd0, m_cnt});
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin : main
        logic rs;
        logic [7:0] ordy;
        reset = 1'b0;
        drive(1'b0, 1'b0, 3'd0, 32'd0, 8'h00);
        bw.in_valid = 1'b0; bw.bcast = 1'b0; bw.in_data = '0;
        bw.sel_2 = 1'b0; bw.sel_1 = 1'b0; bw.sel_0 = 1'b0; bw.out_ready = 8'h00;
        do_reset();

        // Reset state
        chk("rst_valid", {248'd0, bus.out_valid}, 256'd0);
        chk("rst_bus", bus.out_bus, 256'd0);
        chk("rst_cnt", {240'd0, bus.xfer_count}, 256'd0);
        chk("rst_ready", {255'd0, bus.in_ready}, 256'd1);

        // Directed table that starts from the reset state
        vecs[0] = '{1'b1, 1'b0, 3'd5, 32'hDEADBEEF, 8'h00, 1'b1, 8'h20, 16'd1, 5, 32'hDEADBEEF};
        vecs[1] = '{1'b1, 1'b0, 3'd2, 32'h11111111, 8'h00, 1'b1, 8'h24, 16'd2, 2, 32'h11111111};
        vecs[2] = '{1'b1, 1'b0, 3'd2, 32'h22222222, 8'h00, 1'b0, 8'h24, 16'd2, 2, 32'h11111111};
        vecs[3] = '{1'b1, 1'b0, 3'd2, 32'h22222222, 8'h04, 1'b1, 8'h24, 16'd3, 2, 32'h22222222};
        vecs[4] = '{1'b1, 1'b1, 3'd0, 32'h000000A5, 8'h00, 1'b0, 8'h24, 16'd3, 2, 32'h22222222};
        vecs[5] = '{1'b1, 1'b1, 3'd0, 32'h000000A5, 8'h24, 1'b1, 8'hFF, 16'd4, 6, 32'h000000A5};
        vecs[6] = '{1'b0, 1'b1, 3'd3, 32'h12345678, 8'hFF, 1'b1, 8'h00, 16'd4, 6, 32'h000000A5};
        vecs[7] = '{1'b0, 1'b0, 3'd3, 32'h87654321, 8'h00, 1'b1, 8'h00, 16'd4, 0, 32'h000000A5};
        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].v, vecs[i].b, vecs[i].sel, vecs[i].data, vecs[i].ordy);
            cycle(rs);
            chk($sformatf("vec%0d_ready", i), {255'd0, rs}, {255'd0, vecs[i].exp_rdy});
            chk($sformatf("vec%0d_valid", i), {248'd0, bus.out_valid}, {248'd0, vecs[i].exp_valid});
            chk($sformatf("vec%0d_cnt", i), {240'd0, bus.xfer_count}, {240'd0, vecs[i].exp_cnt});
            chk($sformatf("vec%0d_word", i), {224'd0, ch_word(vecs[i].exp_ch)}, {224'd0, vecs[i].exp_word});
        end

        // Broadcast stalled by channel 6: no channel may be written
        drive(1'b1, 1'b0, 3'd6, 32'h66666666, 8'h00);
        cycle(rs);
        drive(1'b1, 1'b1, 3'd1, 32'h000000A5, 8'h00);
        cycle(rs);
        chk("bc_stall_ready", {255'd0, rs}, 256'd0);
        chk("bc_stall_valid", {248'd0, bus.out_valid}, {248'd0, 8'h40});
        drive(1'b1, 1'b1, 3'd1, 32'h000000A5, 8'h40);
        cycle(rs);
        chk("bc_go_valid", {248'd0, bus.out_valid}, {248'd0, 8'hFF});
        chk("bc_go_bus", bus.out_bus, {8{32'h000000A5}});

        // Reset asserted mid-traffic while channel 3 holds a stalled word
        drive(1'b1, 1'b0, 3'd3, 32'h33333333, 8'hFF);
        cycle(rs);
        drive(1'b0, 1'b0, 3'd3, 32'h0, 8'h00);
        #2 reset = 1'b1;
        #1;
        chk("midrst_valid", {248'd0, bus.out_valid}, 256'd0);
        chk("midrst_bus", bus.out_bus, 256'd0);
        chk("midrst_cnt", {240'd0, bus.xfer_count}, 256'd0);
        chk("midrst_ready", {255'd0, bus.in_ready}, 256'd1);
        @(negedge clk);
        reset = 1'b0;
        model_reset();

        // Stream into channel 0 at one word per cycle
        for (int i = 1; i <= 10; i++) begin
            drive(1'b1, 1'b0, 3'd0, 32'(i), 8'h01);
            cycle(rs);
            chk($sformatf("stream%0d_word", i), {224'd0, ch_word(0)}, 256'(i));
            chk($sformatf("stream%0d_v0", i), {255'd0, bus.out_valid[0]}, 256'd1);
        end
        chk("stream_cnt", {240'd0, bus.xfer_count}, 256'd10);

        // Random traffic checked against the model
        for (int i = 0; i < 400; i++) begin
            ordy = 8'($urandom);
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
                  3'($urandom_range(0, 7)), $urandom, ordy);
            cycle(rs);
        end
        drive(1'b0, 1'b0, 3'd0, 32'd0, 8'h00);

        // Counter wrap on the instance with the 4-bit counter
        bw.in_valid = 1'b1;
        bw.out_ready = 8'hFF;
        for (int i = 0; i < 17; i++) begin
            bw.in_data = 32'(i);
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("wrap%0d", i), {252'd0, bw.xfer_count}, 256'((i + 1) % 16));
        end
        bw.in_valid = 1'b0;
        chk("wrap_end", {252'd0, bw.xfer_count}, 256'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
